uart_alu_ctrl: RTL
==================

UART_ALU_CTRL -- requirements
Module: uart_alu_ctrl

Interface
REQ-001 Parameter DBIT, default 8: data byte width, equal to the uart DBIT.
REQ-002 Parameter OP_W, default 6: ALU opcode width, taken from the low OP_W bits of the opcode byte.
REQ-003 Parameter TIMEOUT, default 10000000: idle clocks allowed between bytes of one frame.
REQ-004 Parameter TO_W, default 24: timeout counter width; 2^TO_W SHALL exceed TIMEOUT.
REQ-005 i_clk  in  1  system clock; the block has exactly one clock.
REQ-006 i_reset  in  1  reset, asynchronous and active-low.
REQ-007 i_rx_empty  in  1  uart receive FIFO empty.
REQ-008 i_r_data  in  DBIT  receive FIFO head byte (first-word fall-through), valid while i_rx_empty=0.
REQ-009 o_rd_uart  out  1  one-clock pop pulse to the receive FIFO.
REQ-010 i_tx_full  in  1  uart transmit FIFO full.
REQ-011 o_wr_uart  out  1  one-clock push pulse to the transmit FIFO.
REQ-012 o_w_data  out  DBIT  byte pushed to the transmit FIFO.
REQ-013 o_alu_a, o_alu_b  out  DBIT each  registered operands to the external combinational ALU.
REQ-014 o_alu_op  out  OP_W  registered opcode to the ALU.
REQ-015 i_alu_result  in  DBIT  ALU result, combinational from o_alu_*.
REQ-016 o_busy  out  1  high in every state except WAIT_A.
REQ-017 o_timeout  out  1  one-clock pulse when a partial frame is abandoned.

Function
REQ-018 FSM states SHALL be exactly: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND.
REQ-019 In WAIT_A/WAIT_B/WAIT_OP with i_rx_empty=0: capture i_r_data into A/B/opcode, assert o_rd_uart for that cycle only, and advance to the next state.
REQ-020 Capture and pop SHALL be at most one per clock; o_rd_uart SHALL never be asserted while i_rx_empty=1.
REQ-021 WAIT_OP->EXEC; EXEC SHALL register i_alu_result into the result register in exactly one clock, then go to SEND.
REQ-022 In SEND with i_tx_full=0: o_w_data=result, o_wr_uart=1 for one clock, go to WAIT_A; while i_tx_full=1 hold SEND with o_wr_uart=0 and no timeout.
REQ-023 Latency from the opcode pop to o_wr_uart SHALL be 2 clocks when i_tx_full=0.
REQ-024 o_alu_a/o_alu_b/o_alu_op SHALL hold their values until overwritten by the next frame.
REQ-025 Timeout counter: clear on every pop and on entry to WAIT_A; increment each clock in WAIT_B or WAIT_OP while i_rx_empty=1.
REQ-026 Counter reaching TIMEOUT-1 SHALL pulse o_timeout for one clock, return to WAIT_A and discard partial operands; it SHALL saturate, never wrap.
REQ-027 If a byte arrives on the same clock the counter reaches TIMEOUT-1, the byte SHALL win: capture, pop, advance, no timeout.
REQ-028 WAIT_A SHALL never time out.

Reset
REQ-029 On i_reset=0, asynchronously: state=WAIT_A; A, B, opcode, result, counter = 0; all outputs 0.
REQ-030 Reset asserted mid-frame SHALL discard the frame; no o_wr_uart SHALL follow release until a new complete frame is received.

Structure
REQ-031 State encodings and the default DBIT/OP_W/TIMEOUT values SHALL live in a shared include/package (uart_alu_pkg) used by the top-level.
REQ-032 The timeout counter SHALL be one sub-module, frame_timer (clear, enable, saturating terminal-count pulse); all other logic is flat.

Verification
REQ-033 Bytes 0x05, 0x03, 0x20 with ALU model ADD -> exactly one o_wr_uart, o_w_data=0x08, 2 clocks after the third pop.
REQ-034 Three bytes back-to-back on consecutive clocks -> three single-cycle o_rd_uart pulses; o_alu_a=0x05, o_alu_b=0x03, o_alu_op=0x20.
REQ-035 i_tx_full=1 for 50 clocks in SEND -> no push and no o_timeout; push occurs 1 clock after i_tx_full falls.
REQ-036 Byte A=0x11, then TIMEOUT=16 idle clocks -> o_timeout pulse on the 16th idle clock, state WAIT_A; next frame 0x02, 0x02, ADD -> 0x04.
REQ-037 i_reset=0 while in WAIT_OP -> all outputs 0 immediately; no push after release.
REQ-038 Byte arrives on the terminal-count clock -> pop, no o_timeout.

Source files
------------

// File: rtl/uart_alu_pkg.sv
// Shared types and default sizing for the UART-driven ALU controller.
package uart_alu_pkg;

    localparam int DEF_DBIT    = 8;
    localparam int DEF_OP_W    = 6;
    localparam int DEF_TIMEOUT = 10_000_000;
    localparam int DEF_TO_W    = 24;

    // Frame sequencer states: three byte collections, one ALU cycle, one push.
    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        SEND    = 3'd4
    } state_t;

    // True in the states where a frame is partially received and may be abandoned.
    function automatic logic mid_frame(input state_t s);
        return (s == WAIT_B) || (s == WAIT_OP);
    endfunction

endpackage

// File: rtl/uart_alu_ctrl_if.sv
// UART FIFO handshake and ALU operand bus between the controller and its neighbours.
interface uart_alu_ctrl_if
    import uart_alu_pkg::*;
#(
    parameter int DBIT = DEF_DBIT,
    parameter int OP_W = DEF_OP_W
) ();

    // Receive FIFO (first-word fall-through)
    logic            i_rx_empty;
    logic [DBIT-1:0] i_r_data;
    logic            o_rd_uart;

    // Transmit FIFO
    logic            i_tx_full;
    logic            o_wr_uart;
    logic [DBIT-1:0] o_w_data;

    // External combinational ALU
    logic [DBIT-1:0] o_alu_a;
    logic [DBIT-1:0] o_alu_b;
    logic [OP_W-1:0] o_alu_op;
    logic [DBIT-1:0] i_alu_result;

    // Controller side
    modport master (
        input  i_rx_empty, i_r_data, i_tx_full, i_alu_result,
        output o_rd_uart, o_wr_uart, o_w_data, o_alu_a, o_alu_b, o_alu_op
    );

    // FIFO / ALU side
    modport slave (
        output i_rx_empty, i_r_data, i_tx_full, i_alu_result,
        input  o_rd_uart, o_wr_uart, o_w_data, o_alu_a, o_alu_b, o_alu_op
    );

endinterface

// File: rtl/frame_timer.sv
// Inter-byte idle timer: counts enabled clocks, saturates at TIMEOUT-1 and
// flags expiry on every enabled clock spent at that terminal count.
module frame_timer
    import uart_alu_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int TO_W    = DEF_TO_W
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] count_q;
    logic            at_last;

    assign at_last = (count_q == LAST);

    // Count idle clocks; clear wins over enable and the count never wraps.
    always_ff @(posedge i_clk or negedge i_reset) begin
        // NOTE: every register updated in a clocked block uses <=, so all
        // flops sample the pre-edge values regardless of statement order.
        if (!i_reset) begin
            count_q <= '0;
        end else if (i_clear) begin
            count_q <= '0;
        end else if (i_enable && !at_last) begin
            count_q <= count_q + TO_W'(1);
        end
    end

    // Expiry is only meaningful while the owner is actually waiting.
    assign o_expired = i_enable && at_last;

endmodule

// File: rtl/uart_alu_ctrl.sv
// Collects A, B and opcode bytes from the UART receive FIFO, runs them through
// an external combinational ALU and pushes the one-byte result to the transmit
// FIFO. A frame left incomplete for TIMEOUT idle clocks is dropped.
module uart_alu_ctrl
    import uart_alu_pkg::*;
#(
    parameter int DBIT    = DEF_DBIT,
    parameter int OP_W    = DEF_OP_W,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int TO_W    = DEF_TO_W
) (
    input  logic            i_clk,
    input  logic            i_reset,
    uart_alu_ctrl_if.master bus,
    output logic            o_busy,
    output logic            o_timeout
);

    state_t          state_q;
    state_t          state_d;

    logic            pop;
    logic            push;
    logic            timer_en;
    logic            timer_clear;
    logic            timer_expired;

    logic [DBIT-1:0] a_q;
    logic [DBIT-1:0] b_q;
    logic [OP_W-1:0] op_q;
    logic [DBIT-1:0] result_q;

    // The timer only runs while a partial frame is starved of bytes, so an
    // arriving byte always beats expiry on the same clock.
    assign timer_en    = mid_frame(state_q) && bus.i_rx_empty;
    assign timer_clear = pop || (state_d == WAIT_A);

    frame_timer #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_frame_timer (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clear   (timer_clear),
        .i_enable  (timer_en),
        .o_expired (timer_expired)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= WAIT_A;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a waiting byte always advances; expiry only when idle.
    always_comb begin
        // NOTE: defaulting every combinational output before the case keeps
        // paths that do not assign it from inferring a latch.
        state_d = state_q;
        case (state_q)
            WAIT_A: begin
                if (!bus.i_rx_empty) state_d = WAIT_B;
            end
            WAIT_B: begin
                if (!bus.i_rx_empty)   state_d = WAIT_OP;
                else if (timer_expired) state_d = WAIT_A;
            end
            WAIT_OP: begin
                if (!bus.i_rx_empty)   state_d = EXEC;
                else if (timer_expired) state_d = WAIT_A;
            end
            EXEC: begin
                state_d = SEND;
            end
            SEND: begin
                if (!bus.i_tx_full) state_d = WAIT_A;
            end
            default: begin
                state_d = WAIT_A;
            end
        endcase
    end

    // Output decode; the pop is gated by reset so it stays low while the
    // FIFO is non-empty during an asserted reset.
    always_comb begin
        pop       = 1'b0;
        push      = 1'b0;
        o_busy    = 1'b1;
        o_timeout = 1'b0;
        case (state_q)
            WAIT_A: begin
                o_busy = 1'b0;
                pop    = i_reset && !bus.i_rx_empty;
            end
            WAIT_B, WAIT_OP: begin
                pop       = i_reset && !bus.i_rx_empty;
                o_timeout = timer_expired;
            end
            SEND: begin
                push = !bus.i_tx_full;
            end
            default: begin
                push = 1'b0;
            end
        endcase
    end

    // Operand, opcode and result capture; operands persist between frames.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                WAIT_A:  if (pop) a_q  <= bus.i_r_data;
                WAIT_B:  if (pop) b_q  <= bus.i_r_data;
                WAIT_OP: if (pop) op_q <= bus.i_r_data[OP_W-1:0];
                EXEC:    result_q <= bus.i_alu_result;
                default: result_q <= result_q;
            endcase
        end
    end

    assign bus.o_rd_uart = pop;
    assign bus.o_wr_uart = push;
    assign bus.o_w_data  = result_q;
    assign bus.o_alu_a   = a_q;
    assign bus.o_alu_b   = b_q;
    assign bus.o_alu_op  = op_q;

endmodule
